// File: rtl/guess_entry.sv
// Decimal guess entry: per-digit BCD editing with a cursor, commit to binary,
// a limited number of tries and a registered seven-segment view of the entry.
module guess_entry #(
   parameter int DIGITS    = 2,
   parameter int MAX_TRIES = 3,
   parameter int UW        = 7
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   buttonInc,
   input  logic                   buttonDec,
   input  logic                   buttonNext,
   input  logic                   buttonSel,
   input  logic [1:0]             state,
   output logic [4*DIGITS-1:0]    digits,
   output logic [8*DIGITS-1:0]    hexSegs,
   output logic [1:0]             cursor,
   output logic [UW-1:0]          userguess,
   output logic                   guessValid,
   output logic [MAX_TRIES-1:0]   triesLED,
   output logic                   outOfTries
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [7:0] SEG_ZERO = 8'hC0;

   // Active-low segments {dp,g,f,e,d,c,b,a}, decimal point off, blank otherwise.
   function automatic logic [7:0] seg_encode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int k = 0; k < n; k++) begin
         p = p * 32'd10;
      end
      return p;
   endfunction

   // Button history: sampled level and the level one cycle earlier.
   logic [3:0] btn_q, btn_prev_q, btn_d, press;
   logic       press_sel, press_inc, press_dec, press_next;

   logic [1:0]     cursor_q, cursor_d;
   logic [TW-1:0]  tries_q, tries_d;
   logic [UW-1:0]  userguess_q, userguess_d;
   logic           valid_q, valid_d;
   logic [UW-1:0]  guess_sum;

   logic active, new_game;
   logic do_sel, do_inc, do_dec, do_next;

   assign btn_d      = {buttonSel, buttonInc, buttonDec, buttonNext};
   assign press      = btn_q & ~btn_prev_q;
   assign press_sel  = press[3];
   assign press_inc  = press[2];
   assign press_dec  = press[1];
   assign press_next = press[0];

   assign new_game = (state == 2'b00);
   assign active   = (state == 2'b01);

   // A Sel press masks lower-priority presses even when it is refused.
   assign do_sel  = active && press_sel && (tries_q != '0);
   assign do_inc  = active && press_inc && !press_sel;
   assign do_dec  = active && press_dec && !press_sel && !press_inc;
   assign do_next = active && press_next && !press_sel && !press_inc && !press_dec;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         btn_q      <= '0;
         btn_prev_q <= '0;
      end else begin
         btn_q      <= btn_d;
         btn_prev_q <= btn_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] digit_q, digit_d;
         logic [7:0] seg_q;

         always_comb begin
            digit_d = digit_q;
            if (new_game || do_sel) begin
               digit_d = 4'd0;
            end else if (cursor_q == 2'(gi)) begin
               if (do_inc) begin
                  digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
               end else if (do_dec) begin
                  digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
               end
            end
         end

         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               digit_q <= 4'd0;
               seg_q   <= SEG_ZERO;
            end else begin
               digit_q <= digit_d;
               seg_q   <= seg_encode(digit_q);
            end
         end

         assign digits[4*gi +: 4]  = digit_q;
         assign hexSegs[8*gi +: 8] = seg_q;
      end
   endgenerate

   always_comb begin
      guess_sum = '0;
      for (int i = 0; i < DIGITS; i++) begin
         guess_sum = guess_sum + UW'(32'(digits[4*i +: 4]) * pow10(i));
      end
   end

   always_comb begin
      cursor_d    = cursor_q;
      tries_d     = tries_q;
      userguess_d = userguess_q;
      valid_d     = 1'b0;
      if (new_game) begin
         cursor_d    = 2'd0;
         tries_d     = TW'(MAX_TRIES);
         userguess_d = '1;
      end else if (do_sel) begin
         cursor_d    = 2'd0;
         tries_d     = tries_q - 1'b1;
         userguess_d = guess_sum;
         valid_d     = 1'b1;
      end else if (do_next) begin
         cursor_d = (cursor_q == 2'(DIGITS - 1)) ? 2'd0 : cursor_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cursor_q    <= 2'd0;
         tries_q     <= TW'(MAX_TRIES);
         userguess_q <= '1;
         valid_q     <= 1'b0;
      end else begin
         cursor_q    <= cursor_d;
         tries_q     <= tries_d;
         userguess_q <= userguess_d;
         valid_q     <= valid_d;
      end
   end

   generate
      for (gi = 0; gi < MAX_TRIES; gi++) begin : g_led
         assign triesLED[gi] = (int'(tries_q) > gi);
      end
   endgenerate

   assign outOfTries = (tries_q == '0);
   assign cursor     = cursor_q;
   assign userguess  = userguess_q;
   assign guessValid = valid_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry (DIGITS=2, MAX_TRIES=3): editing, commit,
// exhaustion, held and simultaneous buttons, asynchronous reset.
module tb_guess_entry;

   localparam logic [3:0] B_SEL  = 4'b1000;
   localparam logic [3:0] B_INC  = 4'b0100;
   localparam logic [3:0] B_DEC  = 4'b0010;
   localparam logic [3:0] B_NEXT = 4'b0001;

   logic        clk = 1'b0;
   logic        resetN;
   logic        buttonInc, buttonDec, buttonNext, buttonSel;
   logic [1:0]  state;
   logic [7:0]  digits;
   logic [15:0] hexSegs;
   logic [1:0]  cursor;
   logic [6:0]  userguess;
   logic        guessValid;
   logic [2:0]  triesLED;
   logic        outOfTries;

   int tests_run    = 0;
   int tests_failed = 0;

   guess_entry #(.DIGITS(2), .MAX_TRIES(3), .UW(7)) dut (
      .clk        (clk),
      .resetN     (resetN),
      .buttonInc  (buttonInc),
      .buttonDec  (buttonDec),
      .buttonNext (buttonNext),
      .buttonSel  (buttonSel),
      .state      (state),
      .digits     (digits),
      .hexSegs    (hexSegs),
      .cursor     (cursor),
      .userguess  (userguess),
      .guessValid (guessValid),
      .triesLED   (triesLED),
      .outOfTries (outOfTries)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   // One-cycle press; returns on the negedge after the edge that acts on it.
   task automatic press(input logic [3:0] m);
      @(negedge clk);
      {buttonSel, buttonInc, buttonDec, buttonNext} = m;
      @(negedge clk);
      {buttonSel, buttonInc, buttonDec, buttonNext} = 4'b0000;
      @(negedge clk);
   endtask

   initial begin
      resetN = 1'b0;
      state  = 2'b00;
      {buttonSel, buttonInc, buttonDec, buttonNext} = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst_digits", 32'(digits), 32'h00);
      check("rst_cursor", 32'(cursor), 32'd0);
      check("rst_guess", 32'(userguess), 32'h7F);
      check("rst_valid", 32'(guessValid), 32'd0);
      check("rst_leds", 32'(triesLED), 32'b111);
      check("rst_out", 32'(outOfTries), 32'd0);
      check("rst_hex", 32'(hexSegs), 32'hC0C0);

      resetN = 1'b1;
      repeat (2) @(negedge clk);
      state = 2'b01;
      @(negedge clk);

      // Wrap: nine incs reach 9, tenth wraps to 0, dec wraps back to 9
      for (int i = 0; i < 9; i++) press(B_INC);
      check("inc9_digits", 32'(digits), 32'h09);
      press(B_INC);
      check("wrap_inc", 32'(digits), 32'h00);
      press(B_DEC);
      check("wrap_dec", 32'(digits), 32'h09);
      check("hex_lag", 32'(hexSegs), 32'hC0C0);
      @(negedge clk);
      check("hex_9", 32'(hexSegs), 32'hC090);

      // Commit 47
      press(B_DEC);
      press(B_DEC);
      check("digit0_7", 32'(digits), 32'h07);
      press(B_NEXT);
      check("cursor_1", 32'(cursor), 32'd1);
      for (int i = 0; i < 4; i++) press(B_INC);
      check("entry_47", 32'(digits), 32'h47);
      press(B_SEL);
      check("c47_guess", 32'(userguess), 32'd47);
      check("c47_valid", 32'(guessValid), 32'd1);
      check("c47_leds", 32'(triesLED), 32'b011);
      check("c47_digits", 32'(digits), 32'h00);
      check("c47_cursor", 32'(cursor), 32'd0);
      @(negedge clk);
      check("c47_pulse_end", 32'(guessValid), 32'd0);

      // Held button acts once
      buttonInc = 1'b1;
      repeat (20) @(negedge clk);
      buttonInc = 1'b0;
      @(negedge clk);
      check("held_inc", 32'(digits), 32'h01);

      // Sel and Inc together: Sel wins
      press(B_INC);
      press(B_INC);
      check("digit0_3", 32'(digits), 32'h03);
      press(B_SEL | B_INC);
      check("simul_guess", 32'(userguess), 32'd3);
      check("simul_valid", 32'(guessValid), 32'd1);
      check("simul_digits", 32'(digits), 32'h00);
      check("simul_leds", 32'(triesLED), 32'b001);

      // Cursor wrap and partial entry 52
      press(B_NEXT);
      press(B_NEXT);
      check("cursor_wrap", 32'(cursor), 32'd0);
      press(B_INC);
      press(B_INC);
      press(B_NEXT);
      for (int i = 0; i < 5; i++) press(B_INC);
      check("entry_52", 32'(digits), 32'h52);
      @(negedge clk);
      check("hex_52", 32'(hexSegs), 32'h92A4);

      // Asynchronous reset mid-entry, observed before any clock edge
      resetN = 1'b0;
      #1;
      check("arst_digits", 32'(digits), 32'h00);
      check("arst_leds", 32'(triesLED), 32'b111);
      check("arst_cursor", 32'(cursor), 32'd0);
      check("arst_hex", 32'(hexSegs), 32'hC0C0);
      @(negedge clk);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      // Exhaustion
      press(B_SEL);
      check("ex1_guess", 32'(userguess), 32'd0);
      check("ex1_valid", 32'(guessValid), 32'd1);
      check("ex1_leds", 32'(triesLED), 32'b011);
      press(B_SEL);
      check("ex2_leds", 32'(triesLED), 32'b001);
      check("ex2_out", 32'(outOfTries), 32'd0);
      press(B_INC);
      press(B_SEL);
      check("ex3_guess", 32'(userguess), 32'd1);
      check("ex3_leds", 32'(triesLED), 32'b000);
      check("ex3_out", 32'(outOfTries), 32'd1);
      press(B_INC);
      press(B_INC);
      press(B_SEL);
      check("ex4_valid", 32'(guessValid), 32'd0);
      check("ex4_guess", 32'(userguess), 32'd1);
      check("ex4_digits", 32'(digits), 32'h02);

      // Hold phase ignores presses; new game restores everything
      state = 2'b10;
      press(B_INC);
      check("hold_digits", 32'(digits), 32'h02);
      press(B_NEXT);
      check("hold_cursor", 32'(cursor), 32'd0);
      state = 2'b00;
      @(negedge clk);
      check("ng_digits", 32'(digits), 32'h00);
      check("ng_leds", 32'(triesLED), 32'b111);
      check("ng_guess", 32'(userguess), 32'h7F);
      check("ng_out", 32'(outOfTries), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
